// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding for the
// multi-cycle arithmetic blocks and a helper sizing their step counters.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter wide enough to hold every value from 0 up to nsteps inclusive.
    function automatic int cnt_width(input int nsteps);
        return (nsteps < 1) ? 1 : $clog2(nsteps + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Single-bit full subtractor cell: d = x - y - bi, bo set when x < y + bi.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference is plain parity; a borrow is needed when y (plus any
    // incoming borrow) exceeds x.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, STEP bits per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    import arith_pkg::*;

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = cnt_width(NSTEPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NSTEPS - 1);

    // Refuse to build with a width that cannot be split into whole steps.
    generate
        if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
            $fatal(1, "serial_subtractor: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic [STEP:0]    chain_b;
    logic [STEP-1:0]  step_d;
    logic [WIDTH-1:0] diff_next;

    assign chain_b[0] = borrow;

    // Ripple chain of STEP cells working on the low bits of the shift registers.
    generate
        for (genvar i = 0; i < STEP; i++) begin : g_cell
            full_subtractor_bit u_cell (
                .x  (a_sh[i]),
                .y  (b_sh[i]),
                .bi (chain_b[i]),
                .d  (step_d[i]),
                .bo (chain_b[i+1])
            );
        end

        // New result bits enter at the MSB end so the word lines up after NSTEPS.
        if (STEP == WIDTH) begin : g_full_step
            assign diff_next = step_d;
        end else begin : g_part_step
            assign diff_next = {step_d, diff[WIDTH-1:STEP]};
        end
    endgenerate

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_RUN);
    assign bout     = borrow;
    assign ovf      = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);

    // Control FSM with the operand/result shift registers and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            borrow    <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> STEP;
                    b_sh   <= b_sh >> STEP;
                    borrow <= chain_b[STEP];
                    diff   <= diff_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: bit-serial (STEP=1) and
// nibble-serial (STEP=4) instances against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       in_valid1, in_ready1, bin1, out_valid1, out_ready1, bout1, ovf1, busy1;
    logic [7:0] a1, b1, diff1;
    logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, bout4, ovf4, busy4;
    logic [7:0] a4, b4, diff4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_subtractor #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1), .ovf(ovf1), .busy(busy1)
    );

    serial_subtractor #(.WIDTH(8), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .ovf(ovf4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned subtract in 9 bits, borrow is the sign of the result.
    task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                             output logic [7:0] d, output logic bo, output logic ov);
        int r;
        r  = int'(a) - int'(b) - int'(bin);
        d  = r[7:0];
        bo = (r < 0);
        ov = (a[7] != b[7]) && (d[7] != a[7]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands to the selected instance for exactly one accepting edge.
    task automatic start_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin);
        if (sel == 1) begin
            a1 = a; b1 = b; bin1 = bin; in_valid1 = 1'b1;
        end else begin
            a4 = a; b4 = b; bin4 = bin; in_valid4 = 1'b1;
        end
        tick();
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    // Count edges from acceptance until out_valid, and cycles with busy seen.
    task automatic wait_done(input int sel, output int lat, output int busy_seen);
        lat       = 0;
        busy_seen = 0;
        while (!(sel == 1 ? out_valid1 : out_valid4) && lat < 100) begin
            if (sel == 1 ? busy1 : busy4) busy_seen++;
            tick();
            lat++;
        end
    endtask

    task automatic release_result(input int sel);
        if (sel == 1) out_ready1 = 1'b1; else out_ready4 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        out_ready4 = 1'b0;
    endtask

    // Reset values seen on both instances while reset is held.
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({in_ready1, out_valid1, busy1, diff1, bout1, ovf1} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("[TB] FAIL reset_step1: got ir=%b ov=%b bs=%b d=%h bo=%b of=%b, want ir=1 ov=0 bs=0 d=00 bo=0 of=0",
                     in_ready1, out_valid1, busy1, diff1, bout1, ovf1);
        end else pass_cnt++;
        total_cnt++;
        if ({in_ready4, out_valid4, busy4, diff4, bout4, ovf4} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            $display("[TB] FAIL reset_step4: got ir=%b ov=%b bs=%b d=%h bo=%b of=%b, want ir=1 ov=0 bs=0 d=00 bo=0 of=0",
                     in_ready4, out_valid4, busy4, diff4, bout4, ovf4);
        end else pass_cnt++;
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Directed vectors on the bit-serial instance with latency and busy checks.
    task automatic test_directed();
        logic [7:0] va [5] = '{8'h5A, 8'h00, 8'h00, 8'h80, 8'h7F};
        logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'h00, 8'h01, 8'hFF};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ed [5] = '{8'h1E, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bsy;
        for (int i = 0; i < 5; i++) begin
            start_op(1, va[i], vb[i], vc[i]);
            wait_done(1, lat, bsy);
            total_cnt++;
            if (lat !== 8) $display("[TB] FAIL latency_step1[%0d]: got %0d edges, want 8", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (bsy !== 8) $display("[TB] FAIL busy_cycles[%0d]: got %0d, want 8", i, bsy);
            else pass_cnt++;
            total_cnt++;
            if ({diff1, bout1, ovf1} !== {ed[i], eb[i], eo[i]})
                $display("[TB] FAIL directed[%0d] %h-%h-%b: got d=%h bo=%b of=%b, want d=%h bo=%b of=%b",
                         i, va[i], vb[i], vc[i], diff1, bout1, ovf1, ed[i], eb[i], eo[i]);
            else pass_cnt++;
            total_cnt++;
            if ({in_ready1, busy1} !== 2'b00) $display("[TB] FAIL done_decode[%0d]: got ir=%b bs=%b, want 0 0", i, in_ready1, busy1);
            else pass_cnt++;
            release_result(1);
        end
    endtask

    // Result held in DONE under backpressure; new operands are ignored.
    task automatic test_backpressure();
        logic [7:0] d; logic bo, ov;
        int lat, bsy;
        ref_model(8'hC3, 8'h4D, 1'b1, d, bo, ov);
        start_op(1, 8'hC3, 8'h4D, 1'b1);
        wait_done(1, lat, bsy);
        for (int i = 0; i < 5; i++) begin
            a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
            in_valid1 = i[0];
            tick();
            total_cnt++;
            if ({out_valid1, in_ready1, diff1, bout1, ovf1} !== {1'b1, 1'b0, d, bo, ov})
                $display("[TB] FAIL backpressure[%0d]: got ov=%b ir=%b d=%h bo=%b of=%b, want ov=1 ir=0 d=%h bo=%b of=%b",
                         i, out_valid1, in_ready1, diff1, bout1, ovf1, d, bo, ov);
            else pass_cnt++;
        end
        in_valid1 = 1'b0;
        release_result(1);
        total_cnt++;
        if ({in_ready1, out_valid1, busy1} !== 3'b100)
            $display("[TB] FAIL handoff_idle: got ir=%b ov=%b bs=%b, want 1 0 0", in_ready1, out_valid1, busy1);
        else pass_cnt++;
        // out_ready while idle must not disturb anything.
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        total_cnt++;
        if ({in_ready1, out_valid1} !== 2'b10)
            $display("[TB] FAIL idle_out_ready: got ir=%b ov=%b, want 1 0", in_ready1, out_valid1);
        else pass_cnt++;
    endtask

    // Reset in the middle of a run aborts it; the next operation is clean.
    task automatic test_reset_mid_run();
        int lat, bsy;
        start_op(1, 8'hE7, 8'h9C, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid1, busy1, in_ready1} !== 3'b001)
            $display("[TB] FAIL reset_mid_run: got ov=%b bs=%b ir=%b, want 0 0 1", out_valid1, busy1, in_ready1);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        tick();
        start_op(1, 8'h10, 8'h01, 1'b0);
        wait_done(1, lat, bsy);
        total_cnt++;
        if ({lat[7:0], diff1, bout1, ovf1} !== {8'd8, 8'h0F, 1'b0, 1'b0})
            $display("[TB] FAIL after_reset_op: got lat=%0d d=%h bo=%b of=%b, want lat=8 d=0f bo=0 of=0",
                     lat, diff1, bout1, ovf1);
        else pass_cnt++;
        release_result(1);
    endtask

    // Nibble-serial instance: edge-case and random operands, issued back to back.
    task automatic test_random_step4();
        logic [7:0] ta, tb, d; logic tc, bo, ov;
        int lat, bsy, errs;
        errs = 0;
        for (int i = 0; i < 1600; i++) begin
            if (i < 8) begin
                ta = (i[1]) ? 8'hFF : 8'h00;
                tb = (i[2]) ? 8'hFF : ta;
                tc = i[0];
            end else begin
                ta = 8'($urandom);
                tb = (i % 7 == 0) ? ta : 8'($urandom);
                tc = 1'($urandom);
            end
            ref_model(ta, tb, tc, d, bo, ov);
            start_op(4, ta, tb, tc);
            wait_done(4, lat, bsy);
            total_cnt++;
            if (lat !== 2) begin
                $display("[TB] FAIL latency_step4[%0d]: got %0d edges, want 2", i, lat);
            end else pass_cnt++;
            total_cnt++;
            if ({diff4, bout4, ovf4} !== {d, bo, ov}) begin
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL step4[%0d] %h-%h-%b: got d=%h bo=%b of=%b, want d=%h bo=%b of=%b",
                             i, ta, tb, tc, diff4, bout4, ovf4, d, bo, ov);
            end else pass_cnt++;
            release_result(4);
            total_cnt++;
            if (in_ready4 !== 1'b1) $display("[TB] FAIL step4_ready[%0d]: got %b, want 1", i, in_ready4);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random_step4();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
